// File: rtl/ps2_tx_if.sv
// Host-to-device PS/2 transmit bundle: command handshake, sampled line levels
// and open-drain enables.
`timescale 1ns/1ps

interface ps2_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_start, tx_data, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, busy, tx_done, tx_err
    );

    modport slave (
        input  tx_start, tx_data, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host transmitter: inhibits the bus, issues request-to-send, shifts a
// command byte out on device clock edges and checks the device acknowledge.
`timescale 1ns/1ps

module ps2_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int FILT_LEN    = 8
) (
    input  logic      clk,
    input  logic      rst,
    ps2_tx_if.slave   io_ps2
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W = $clog2(10 + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INHIBIT  = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_ACK      = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;

    logic [FILT_LEN-1:0] r_filt_sh;
    logic                r_filt;
    logic [2:0]          r_state;
    logic [9:0]          r_frame;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [INH_W-1:0]    r_inh_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_ps2c_oe;
    logic                r_ps2d_oe;
    logic                r_busy;
    logic                r_tx_done;
    logic                r_tx_err;

    logic                w_fall;
    logic                w_inh_last;
    logic                w_to_hit;

    // The strobe fires in the single cycle where the full window is low but the
    // filtered level has not yet dropped.
    assign w_fall     = r_filt & (r_filt_sh == '0);
    assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYC - 1));
    assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_filt_sh <= '1;
            r_filt    <= 1'b1;
        end else begin
            r_filt_sh <= {r_filt_sh[FILT_LEN-2:0], io_ps2.ps2c_in};
            if (r_filt_sh == '0)
                r_filt <= 1'b0;
            else if (r_filt_sh == '1)
                r_filt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_ps2c_oe <= 1'b0;
            r_ps2d_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_ps2.tx_start) begin
                        r_frame   <= {1'b1, ~^io_ps2.tx_data, io_ps2.tx_data};
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_ps2c_oe <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (w_inh_last) begin
                        r_ps2c_oe <= 1'b0;
                        r_ps2d_oe <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= ST_SEND;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + INH_W'(1);
                    end
                end
                ST_SEND, ST_ACK, ST_WAIT_REL: begin
                    // Timeout wins over any line event so done/err stay exclusive.
                    if (w_to_hit) begin
                        r_ps2c_oe <= 1'b0;
                        r_ps2d_oe <= 1'b0;
                        r_tx_err  <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (r_state == ST_SEND) begin
                            if (w_fall) begin
                                r_ps2d_oe <= ~r_frame[r_bit_cnt];
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                                if (r_bit_cnt == BIT_W'(9))
                                    r_state <= ST_ACK;
                            end
                        end else if (r_state == ST_ACK) begin
                            if (w_fall) begin
                                if (!io_ps2.ps2d_in) begin
                                    r_state <= ST_WAIT_REL;
                                end else begin
                                    r_tx_err <= 1'b1;
                                    r_busy   <= 1'b0;
                                    r_state  <= ST_IDLE;
                                end
                            end
                        end else begin
                            if (r_filt && io_ps2.ps2d_in) begin
                                r_tx_done <= 1'b1;
                                r_busy    <= 1'b0;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_ps2c_oe <= 1'b0;
                    r_ps2d_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_ps2.ps2c_oe = r_ps2c_oe;
    assign io_ps2.ps2d_oe = r_ps2d_oe;
    assign io_ps2.busy    = r_busy;
    assign io_ps2.tx_done = r_tx_done;
    assign io_ps2.tx_err  = r_tx_err;

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, meaning the number of clk cycles the host holds PS/2 clock low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the clk-cycle limit for the device-clocked phase, measured from SEND entry (20 ms at 50 MHz).
REQ-003 SHALL have parameter FILT_LEN, default 8, meaning the ps2c glitch-filter depth in samples.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 tx_start  in  1  one-cycle request to send tx_data; honoured only in IDLE.
REQ-007 tx_data  in  8  command byte to the device.
REQ-008 ps2c_in  in  1  sampled PS/2 clock line.
REQ-009 ps2d_in  in  1  sampled PS/2 data line.
REQ-010 ps2c_oe  out  1  1 = drive PS/2 clock low, 0 = release (open-drain).
REQ-011 ps2d_oe  out  1  1 = drive PS/2 data low, 0 = release.
REQ-012 busy  out  1  high from the cycle after an accepted tx_start until the cycle tx_done or tx_err is asserted; gates the keyboard receiver.
REQ-013 tx_done  out  1  one-cycle pulse: frame acknowledged and lines released.
REQ-014 tx_err  out  1  one-cycle pulse: no ack or timeout.

Function
REQ-015 ps2c filter SHALL be a FILT_LEN-bit shift register: filtered level goes 0 only when all samples are 0, goes 1 only when all are 1, otherwise holds.
REQ-016 A device clock edge SHALL be a filtered 1->0 transition, detected as a one-cycle strobe.
REQ-017 States SHALL be IDLE, INHIBIT, SEND, ACK, WAIT_REL.
REQ-018 IDLE: busy=0, both oe=0; on tx_start, latch frame {stop=1, parity=~^tx_data, tx_data}, clear the bit counter, go INHIBIT.
REQ-019 INHIBIT: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYC cycles, then go SEND.
REQ-020 SEND entry: in the same cycle, ps2c_oe=0 and ps2d_oe=1 (start bit); reset and start the timeout counter.
REQ-021 SEND: on falling edges 1..10, ps2d_oe SHALL become ~bit, bits ordered data[0]..data[7], parity, stop; the stop bit releases ps2d; after edge 10, go ACK.
REQ-022 ACK: on edge 11, sample ps2d_in: 0 -> WAIT_REL; 1 -> tx_err pulse, go IDLE.
REQ-023 WAIT_REL: when filtered ps2c=1 and ps2d_in=1, pulse tx_done and go IDLE.
REQ-024 In SEND, ACK and WAIT_REL, when the timeout counter reaches TIMEOUT_CYC: release both oe, pulse tx_err, go IDLE.
REQ-025 tx_start outside IDLE SHALL be ignored with no side effect.
REQ-026 tx_done and tx_err SHALL never be asserted together.
REQ-027 Counter widths SHALL be $clog2(param+1); no counter wraps.

Reset
REQ-028 While rst=0 at a clock edge: state=IDLE; ps2c_oe, ps2d_oe, busy, tx_done and tx_err = 0; counters=0; filter preset to all ones (filtered ps2c=1).
REQ-029 Reset mid-frame SHALL release both lines on the next clock edge with no tx_done or tx_err pulse; the device is left to time out.

Verification
REQ-030 tx_start with 0xED, BFM device acks -> ps2c_oe high for exactly INHIBIT_CYC cycles; bits seen 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse; busy falls.
REQ-031 tx_data 0xF4 -> parity bit 0; all else as REQ-030.
REQ-032 BFM holds ps2d high at edge 11 -> one tx_err pulse, no tx_done, IDLE.
REQ-033 TIMEOUT_CYC=200, BFM stops after 4 clocks -> tx_err exactly 200 cycles after SEND entry, both oe=0.
REQ-034 ps2c glitches 3 cycles long during SEND, plus a tx_start while busy -> no bit advance, frame unchanged.
REQ-035 rst=0 at bit 5 -> next cycle both oe=0, busy=0, no pulses; a fresh tx_start then completes normally.
